fft_dif_sched: RTL and testbench

//  Sequencer for an in-place radix-2 DIF FFT built around one registered butterfly (1-cycle latency).
//  Per stage it generates sample-RAM read/write addresses, twiddle ROM addresses and the butterfly enable.

---
 rtl/fft_dif_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_fft_dif_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_dif_sched.sv
`default_nettype none
// ============================================================================
// Module      : fft_dif_sched
// Description : Address/strobe sequencer for an in-place radix-2 DIF FFT
//               built around one registered butterfly. Optional bit-reversed
//               unload phase when FFT_BITREV_UNLOAD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_dif_sched #(
  parameter int N      = 64,
  parameter int LOGN   = 6,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_addr,
  output logic            bf_enable,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
`ifdef FFT_BITREV_UNLOAD_EN
  ,
  output logic            unl_rd_en,
  output logic            unl_valid,
  output logic [LOGN-1:0] unl_index
`endif
);

  localparam int c_CW = $clog2(RD_LAT + 2);
  localparam logic [LOGN-1:0] c_HALF  = LOGN'(N / 2);
  localparam logic [LOGN-1:0] c_KLAST = LOGN'(N / 2 - 1);
  localparam logic [LOGN-1:0] c_SLAST = LOGN'(LOGN - 1);
  localparam logic [c_CW-1:0] c_DRAIN = c_CW'(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_UNLOAD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state, w_state_nx;
  logic [LOGN-1:0]   r_k, w_k_nx;
  logic [LOGN-1:0]   r_stage, w_stage_nx;
  logic [c_CW-1:0]   r_cnt, w_cnt_nx;

  logic [LOGN-1:0]   w_span, w_mask, w_j, w_tw, w_iss_a, w_iss_b;

  // Delay pipe: index 1 holds the values issued one cycle earlier
  logic              r_pv [1:RD_LAT+1];
  logic [LOGN-1:0]   r_pa [1:RD_LAT+1];
  logic [LOGN-1:0]   r_pb [1:RD_LAT+1];

`ifdef FFT_BITREV_UNLOAD_EN
  localparam int c_UW = $clog2(N + RD_LAT + 1);
  localparam logic [c_UW-1:0] c_ULAST = c_UW'(N + RD_LAT - 1);
  localparam logic [c_UW-1:0] c_UN    = c_UW'(N);
  logic [c_UW-1:0]   r_ucnt, w_ucnt_nx;
  logic [LOGN-1:0]   w_n, w_rev;
  logic              r_uv [1:RD_LAT];
  logic [LOGN-1:0]   r_un [1:RD_LAT];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_stage <= '0;
      r_cnt   <= '0;
`ifdef FFT_BITREV_UNLOAD_EN
      r_ucnt  <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_stage <= w_stage_nx;
      r_cnt   <= w_cnt_nx;
`ifdef FFT_BITREV_UNLOAD_EN
      r_ucnt  <= w_ucnt_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_stage_nx = r_stage;
    w_cnt_nx   = r_cnt;
`ifdef FFT_BITREV_UNLOAD_EN
    w_ucnt_nx  = r_ucnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_ISSUE;
          w_k_nx     = '0;
          w_stage_nx = '0;
        end
      end
      S_ISSUE: begin
        if (r_k == c_KLAST) begin
          w_state_nx = S_DRAIN;
          w_cnt_nx   = c_CW'(1);
        end else begin
          w_k_nx = r_k + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == c_DRAIN) begin
          if (r_stage == c_SLAST) begin
`ifdef FFT_BITREV_UNLOAD_EN
            w_state_nx = S_UNLOAD;
            w_ucnt_nx  = '0;
`else
            w_state_nx = S_DONE;
`endif
          end else begin
            w_state_nx = S_ISSUE;
            w_stage_nx = r_stage + 1'b1;
            w_k_nx     = '0;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_UNLOAD: begin
`ifdef FFT_BITREV_UNLOAD_EN
        // Runs RD_LAT extra cycles so the last unl_valid precedes done
        if (r_ucnt == c_ULAST) w_state_nx = S_DONE;
        else                   w_ucnt_nx  = r_ucnt + 1'b1;
`else
        w_state_nx = S_IDLE;
`endif
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_stage_nx = '0;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Pair k splits into group bits (above span) and offset j (below span)
  always_comb begin
    w_span  = c_HALF >> r_stage;
    w_mask  = w_span - 1'b1;
    w_j     = r_k & w_mask;
    w_iss_a = '0;
    w_iss_b = '0;
    w_tw    = '0;
    if (r_state == S_ISSUE) begin
      w_iss_a = ((r_k & ~w_mask) << 1) | w_j;
      w_iss_b = w_iss_a | w_span;
      w_tw    = w_j << r_stage;
    end
  end

  assign busy    = (r_state == S_ISSUE) || (r_state == S_DRAIN) || (r_state == S_UNLOAD);
  assign done    = (r_state == S_DONE);
  assign stage   = r_stage;
  assign rd_en   = (r_state == S_ISSUE);
  assign rd_addr_b = w_iss_b;
  assign tw_addr   = w_tw[LOGN-2:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= RD_LAT + 1; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_pv[1] <= rd_en;
      r_pa[1] <= w_iss_a;
      r_pb[1] <= w_iss_b;
      for (int i = 2; i <= RD_LAT + 1; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  assign bf_enable = r_pv[RD_LAT];
  assign wr_en     = r_pv[RD_LAT+1];
  assign wr_addr_a = r_pa[RD_LAT+1];
  assign wr_addr_b = r_pb[RD_LAT+1];

`ifdef FFT_BITREV_UNLOAD_EN
  assign unl_rd_en = (r_state == S_UNLOAD) && (r_ucnt < c_UN);
  assign w_n       = r_ucnt[LOGN-1:0];

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < LOGN; i++) w_rev[i] = w_n[LOGN-1-i];
  end

  assign rd_addr_a = unl_rd_en ? w_rev : w_iss_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= RD_LAT; i++) begin
        r_uv[i] <= 1'b0;
        r_un[i] <= '0;
      end
    end else begin
      r_uv[1] <= unl_rd_en;
      r_un[1] <= unl_rd_en ? w_n : '0;
      for (int i = 2; i <= RD_LAT; i++) begin
        r_uv[i] <= r_uv[i-1];
        r_un[i] <= r_un[i-1];
      end
    end
  end

  assign unl_valid = r_uv[RD_LAT];
  assign unl_index = r_un[RD_LAT];
`else
  assign rd_addr_a = w_iss_a;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_dif_sched.sv
`default_nettype none
// Directed testbench for fft_dif_sched (N=64, RD_LAT=1); adds an N=8 unload
// instance when FFT_BITREV_UNLOAD_EN is defined.
module tb_fft_dif_sched;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_en, bf_enable, wr_en;
  logic [5:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [4:0] tw_addr;
  int checks = 0;
  int errors = 0;

`ifdef FFT_BITREV_UNLOAD_EN
  localparam int T = 205 + 64 + 1;
  logic       unl_rd_en, unl_valid;
  logic [5:0] unl_index;
`else
  localparam int T = 205;
`endif

  always #5 clk = ~clk;

  fft_dif_sched #(.N(64), .LOGN(6), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr), .bf_enable(bf_enable), .wr_en(wr_en),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
`ifdef FFT_BITREV_UNLOAD_EN
    , .unl_rd_en(unl_rd_en), .unl_valid(unl_valid), .unl_index(unl_index)
`endif
  );

`ifdef FFT_BITREV_UNLOAD_EN
  logic       start8 = 1'b0;
  logic       busy8, done8, rd_en8, bf8, wr8, urd8, uv8;
  logic [2:0] stage8, ra8, rb8, wa8, wb8, ui8;
  logic [1:0] tw8;
  fft_dif_sched #(.N(8), .LOGN(3), .RD_LAT(1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .busy(busy8), .done(done8),
    .stage(stage8), .rd_en(rd_en8), .rd_addr_a(ra8), .rd_addr_b(rb8),
    .tw_addr(tw8), .bf_enable(bf8), .wr_en(wr8), .wr_addr_a(wa8), .wr_addr_b(wb8),
    .unl_rd_en(urd8), .unl_valid(uv8), .unl_index(ui8)
  );
`endif

  // Reference schedule: cycle c=1 is the first cycle after start is accepted
  task automatic model(input int c, output logic iss, output logic [5:0] a,
                       output logic [5:0] b, output logic [4:0] tw, output logic [5:0] s);
    int p, span, si;
    iss = 1'b0; a = '0; b = '0; tw = '0; s = '0;
    if (c >= 1 && c <= 204) begin
      si = (c - 1) / 34;
      p  = (c - 1) % 34;
      s  = 6'(si);
      if (p < 32) begin
        span = 64 >> (si + 1);
        iss  = 1'b1;
        a    = 6'(2 * (p / span) * span + p % span);
        b    = 6'(2 * (p / span) * span + p % span + span);
        tw   = 5'((p % span) << si);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, bf_enable, wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {busy, done, rd_en, bf_enable, wr_en});
    end
    checks++;
    if ({stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 35'b0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0",
               {stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_transform;
    logic       ei, bi, wi;
    logic [5:0] ea, eb, es, ba, bb, bs, wa, wb, ws;
    logic [4:0] et, bt, wt;
    start = 1'b1;
    for (int c = 1; c <= T + 1; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      model(c, ei, ea, eb, et, es);
      model(c - 1, bi, ba, bb, bt, bs);
      model(c - 2, wi, wa, wb, wt, ws);
      checks++;
      if (busy !== (c < T)) begin
        errors++;
        $display("FAIL busy c=%0d got %b want %b", c, busy, c < T);
      end
      checks++;
      if (done !== (c == T)) begin
        errors++;
        $display("FAIL done c=%0d got %b want %b", c, done, c == T);
      end
      checks++;
      if (rd_en !== ei) begin
        errors++;
        $display("FAIL rd_en c=%0d got %b want %b", c, rd_en, ei);
      end
      if (ei) begin
        checks++;
        if ({rd_addr_a, rd_addr_b, tw_addr, stage} !== {ea, eb, et, es}) begin
          errors++;
          $display("FAIL rd_addr c=%0d got a=%0d b=%0d tw=%0d s=%0d want a=%0d b=%0d tw=%0d s=%0d",
                   c, rd_addr_a, rd_addr_b, tw_addr, stage, ea, eb, et, es);
        end
      end
      checks++;
      if (bf_enable !== bi) begin
        errors++;
        $display("FAIL bf_enable c=%0d got %b want %b", c, bf_enable, bi);
      end
      checks++;
      if (wr_en !== wi) begin
        errors++;
        $display("FAIL wr_en c=%0d got %b want %b", c, wr_en, wi);
      end
      if (wi) begin
        checks++;
        if ({wr_addr_a, wr_addr_b} !== {wa, wb}) begin
          errors++;
          $display("FAIL wr_addr c=%0d got %0d/%0d want %0d/%0d", c, wr_addr_a, wr_addr_b, wa, wb);
        end
      end
      // Hand-computed anchor points
      if (c == 1 || c == 35 || c == 36 || c == 51 || c == 171 || c == 172) begin
        checks++;
        if ({rd_addr_a, rd_addr_b, tw_addr} !==
            ((c == 1)   ? {6'd0, 6'd32, 5'd0} :
             (c == 35)  ? {6'd0, 6'd16, 5'd0} :
             (c == 36)  ? {6'd1, 6'd17, 5'd2} :
             (c == 51)  ? {6'd32, 6'd48, 5'd0} :
             (c == 171) ? {6'd0, 6'd1, 5'd0} : {6'd2, 6'd3, 5'd0})) begin
          errors++;
          $display("FAIL anchor c=%0d got a=%0d b=%0d tw=%0d", c, rd_addr_a, rd_addr_b, tw_addr);
        end
      end
      if (c == T + 1) begin
        checks++;
        if (stage !== 6'd0) begin
          errors++;
          $display("FAIL idle_stage got %0d want 0", stage);
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    int dcyc = 0;
    start = 1'b1;
    for (int c = 1; c <= T + 5; c++) begin
      @(posedge clk);
      #1;
      start = (c == 10 || c == 50);
      if (done === 1'b1) begin
        ndone++;
        dcyc = c;
      end
    end
    checks++;
    if (ndone != 1 || dcyc != T) begin
      errors++;
      $display("FAIL start_ignored got %0d dones at %0d want 1 at %0d", ndone, dcyc, T);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_requeue busy got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    start = 1'b1;
    for (int c = 1; c <= 2 * T + 2; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (c != T && c != 2 * T + 1) begin
          errors++;
          $display("FAIL b2b_done_pos got %0d want %0d or %0d", c, T, 2 * T + 1);
        end
      end
      if (c == T + 1) begin
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle got busy=%b rd_en=%b want 0/0", busy, rd_en);
        end
      end
      if (c == T + 2) begin
        start = 1'b0;
        checks++;
        if ({busy, rd_en, rd_addr_a, rd_addr_b} !== {1'b1, 1'b1, 6'd0, 6'd32}) begin
          errors++;
          $display("FAIL b2b_restart got busy=%b rd_en=%b a=%0d b=%0d want 1 1 0 32",
                   busy, rd_en, rd_addr_a, rd_addr_b);
        end
      end
    end
    checks++;
    if (ndone != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count got %0d dones busy=%b want 2 busy=0", ndone, busy);
    end
  endtask

  task automatic test_reset_abort;
    int nwr = 0;
    start = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    checks++;
    if ({stage, rd_addr_a, rd_addr_b, tw_addr} !== {6'd3, 6'd11, 6'd15, 5'd24}) begin
      errors++;
      $display("FAIL abort_pair got s=%0d a=%0d b=%0d tw=%0d want 3 11 15 24",
               stage, rd_addr_a, rd_addr_b, tw_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, bf_enable, wr_en, stage, rd_addr_a, rd_addr_b, tw_addr,
         wr_addr_a, wr_addr_b} !== 40'b0) begin
      errors++;
      $display("FAIL abort_async got %h want 0",
               {busy, done, rd_en, bf_enable, wr_en, stage, rd_addr_a, rd_addr_b, tw_addr,
                wr_addr_a, wr_addr_b});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) nwr++;
    end
    checks++;
    if (nwr != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles want 0", nwr);
    end
  endtask

`ifdef FFT_BITREV_UNLOAD_EN
  task automatic test_unload;
    logic [2:0] rev [8];
    rev = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    start8 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      start8 = 1'b0;
      checks++;
      if (urd8 !== (c >= 19 && c <= 26)) begin
        errors++;
        $display("FAIL unl_rd_en c=%0d got %b", c, urd8);
      end
      if (c >= 19 && c <= 26) begin
        checks++;
        if (ra8 !== rev[c-19]) begin
          errors++;
          $display("FAIL unl_addr c=%0d got %0d want %0d", c, ra8, rev[c-19]);
        end
      end
      checks++;
      if (uv8 !== (c >= 20 && c <= 27) || (uv8 === 1'b1 && ui8 !== 3'(c - 20))) begin
        errors++;
        $display("FAIL unl_valid c=%0d got v=%b i=%0d", c, uv8, ui8);
      end
      checks++;
      if (done8 !== (c == 28)) begin
        errors++;
        $display("FAIL unl_done c=%0d got %b want %b", c, done8, c == 28);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_transform();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
`ifdef FFT_BITREV_UNLOAD_EN
    test_unload();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
